collision_detector: RTL

- Sits directly downstream of the obstacle generator and consumes its 10-slot obstacle array plus the player lane and jump signals it passes through.
- Owns the player jump airtime state.
- Once per video frame, snapshots the obstacle state and scans the slots sequentially, one per cycle, for overlap with the player's hitbox.
- Raises a sticky game-over indication that the game controller uses to freeze play and drive the game reset.

---
 rtl/collision_detector_pkg.sv | 29 ++
 rtl/collision_detector_jump_timer.sv | 55 +++++
 rtl/collision_detector.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/collision_detector_pkg.sv
//------------------------------------------------------------------------------
// collision_detector_pkg : shared obstacle record, screen constants, FSM states
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package collision_detector_pkg;

    localparam int NUM_OBSTACLES  = 10;
    localparam int OBSTACLE_WIDTH = 32;
    localparam int SCREEN_WIDTH   = 1024;

    // position is the obstacle's right edge in screen pixels
    typedef struct packed {
        logic [1:0]  sprite_type;
        logic [10:0] position;
        logic [1:0]  lane;
        logic        active;
    } obstacle_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_RESOLVE = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/collision_detector_jump_timer.sv
//------------------------------------------------------------------------------
// collision_detector_jump_timer : jump edge detect and frame-based airtime count
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module collision_detector_jump_timer #(
    parameter int JUMP_FRAMES = 30
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic game_reset,
    input  logic frame_tick_in,
    input  logic jump_in,
    input  logic game_over_in,
    output logic airborne_out
);

    localparam int              c_cnt_w = $clog2(JUMP_FRAMES + 1);
    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(JUMP_FRAMES);

    logic               r_jump_prev_q;
    logic [c_cnt_w-1:0] r_air_count_q;
    logic [c_cnt_w-1:0] w_air_count_d;
    logic               w_jump_edge;

    assign airborne_out = (r_air_count_q != '0);

    // A load beats a same-cycle decrement; no reload while airborne.
    always_comb begin
        w_jump_edge   = jump_in & ~r_jump_prev_q;
        w_air_count_d = r_air_count_q;
        if (game_reset) begin
            w_air_count_d = '0;
        end else if (w_jump_edge && !airborne_out && !game_over_in) begin
            w_air_count_d = c_load;
        end else if (frame_tick_in && airborne_out) begin
            w_air_count_d = r_air_count_q - c_cnt_w'(1);
        end
    end

    // Edge history survives game_reset so a held button does not re-trigger.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_jump_prev_q <= 1'b0;
            r_air_count_q <= '0;
        end else begin
            r_jump_prev_q <= jump_in;
            r_air_count_q <= w_air_count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/collision_detector.sv
//------------------------------------------------------------------------------
// collision_detector : per-frame sequential obstacle scan with sticky game-over
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int         PLAYER_X      = 128,
    parameter int         PLAYER_WIDTH  = 32,
    parameter int         JUMP_FRAMES   = 30,
    parameter logic [3:0] JUMPABLE_MASK = 4'b0011
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          game_reset,
    input  logic                          frame_tick_in,
    input  obstacle_t [NUM_OBSTACLES-1:0] obstacles_in,
    input  logic [1:0]                    lane_in,
    input  logic                          jump_in,
    output logic                          airborne_out,
    output logic                          game_over_out,
    output logic                          collision_pulse_out,
    output logic [3:0]                    hit_index_out,
    output logic                          scan_busy_out,
    output logic                          overrun_out
);

    localparam logic [11:0] c_lo       = 12'(PLAYER_X);
    localparam logic [11:0] c_hi       = 12'(PLAYER_X + PLAYER_WIDTH + OBSTACLE_WIDTH);
    localparam logic [3:0]  c_last_idx = 4'(NUM_OBSTACLES - 1);

    scan_state_t                   r_state;
    obstacle_t [NUM_OBSTACLES-1:0] r_snap_obs;
    logic [1:0]                    r_snap_lane;
    logic                          r_snap_airborne;
    logic [3:0]                    r_idx;
    logic                          r_hit_found;
    logic [3:0]                    r_hit_idx;
    logic                          r_game_over;
    logic                          r_pulse;
    logic [3:0]                    r_hit_index;
    logic                          r_overrun;

    obstacle_t   w_cur;
    logic [11:0] w_pos;
    logic        w_overlap;
    logic        w_hit;
    logic        w_airborne;

    collision_detector_jump_timer #(
        .JUMP_FRAMES (JUMP_FRAMES)
    ) u_jump_timer (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .game_reset    (game_reset),
        .frame_tick_in (frame_tick_in),
        .jump_in       (jump_in),
        .game_over_in  (r_game_over),
        .airborne_out  (w_airborne)
    );

    // 12-bit compare so spawn positions past the screen edge cannot wrap.
    always_comb begin
        w_cur     = r_snap_obs[r_idx];
        w_pos     = {1'b0, w_cur.position};
        w_overlap = (w_pos > c_lo) && (w_pos < c_hi);
        w_hit     = w_cur.active && (w_cur.lane == r_snap_lane) && w_overlap &&
                    !(r_snap_airborne && JUMPABLE_MASK[w_cur.sprite_type]);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state         <= ST_IDLE;
            r_snap_obs      <= '0;
            r_snap_lane     <= '0;
            r_snap_airborne <= 1'b0;
            r_idx           <= '0;
            r_hit_found     <= 1'b0;
            r_hit_idx       <= '0;
            r_game_over     <= 1'b0;
            r_pulse         <= 1'b0;
            r_hit_index     <= '0;
            r_overrun       <= 1'b0;
        end else if (game_reset) begin
            r_state         <= ST_IDLE;
            r_snap_obs      <= '0;
            r_snap_lane     <= '0;
            r_snap_airborne <= 1'b0;
            r_idx           <= '0;
            r_hit_found     <= 1'b0;
            r_hit_idx       <= '0;
            r_game_over     <= 1'b0;
            r_pulse         <= 1'b0;
            r_hit_index     <= '0;
            r_overrun       <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (frame_tick_in && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick_in && !r_game_over) begin
                        r_snap_obs      <= obstacles_in;
                        r_snap_lane     <= lane_in;
                        r_snap_airborne <= w_airborne;
                        r_idx           <= '0;
                        r_hit_found     <= 1'b0;
                        r_state         <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_hit && !r_hit_found) begin
                        r_hit_found <= 1'b1;
                        r_hit_idx   <= r_idx;
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_RESOLVE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_RESOLVE: begin
                    if (r_hit_found) begin
                        r_game_over <= 1'b1;
                        r_pulse     <= 1'b1;
                        r_hit_index <= r_hit_idx;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign airborne_out        = w_airborne;
    assign game_over_out       = r_game_over;
    assign collision_pulse_out = r_pulse;
    assign hit_index_out       = r_hit_index;
    assign scan_busy_out       = (r_state != ST_IDLE);
    assign overrun_out         = r_overrun;

endmodule

`default_nettype wire
